// File: rtl/axi_wcmd_gen.sv
// Write-command generator: splits a beat count into AXI INCR bursts (<= MAX_BURST beats, never
// crossing a 4 KB page) and hands them one at a time to the write bridge over a valid/ready port.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | size the next burst from addr/remain, register the command
// ISSUE | command valid, waiting for wstart_rdy
// FIN   | done pulse, drop busy
module axi_wcmd_gen #(
    parameter int DATA_WDTH = 32,
    parameter int ADDR_WDTH = 32,
    parameter int MAX_BURST = 16,
    parameter int LEN_WDTH  = 24
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 soft_rst,
    input  logic                 start,
    input  logic [ADDR_WDTH-1:0] cfg_base_addr,
    input  logic [LEN_WDTH-1:0]  cfg_total_beats,
    output logic                 busy,
    output logic                 done,
    output logic                 wstart_vld,
    input  logic                 wstart_rdy,
    output logic [ADDR_WDTH-1:0] waddr,
    output logic [7:0]           wburst_len,
    output logic [15:0]          dbg_burst_cnt
);

    localparam int BPB = DATA_WDTH / 8;
    localparam int BSH = $clog2(BPB);
    localparam int CW  = ((LEN_WDTH > 13) ? LEN_WDTH : 13) + 1;
    localparam logic [ADDR_WDTH-1:0] ALIGN_MASK = ~ADDR_WDTH'(BPB - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_ISSUE = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t               r_state;
    logic [ADDR_WDTH-1:0] r_addr;
    logic [LEN_WDTH-1:0]  r_remain;
    logic [8:0]           r_beats;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_wstart_vld;
    logic [ADDR_WDTH-1:0] r_waddr;
    logic [7:0]           r_wburst_len;
    logic [15:0]          r_burst_cnt;

    state_t               w_state_nxt;
    logic [ADDR_WDTH-1:0] w_addr_nxt;
    logic [LEN_WDTH-1:0]  w_remain_nxt;
    logic [8:0]           w_beats_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;
    logic                 w_wstart_vld_nxt;
    logic [ADDR_WDTH-1:0] w_waddr_nxt;
    logic [7:0]           w_wburst_len_nxt;
    logic [15:0]          w_burst_cnt_nxt;

    logic                 w_rst;
    logic [12:0]          w_bnd13;
    logic [12:0]          w_bnd_beats;
    logic [CW-1:0]        w_remain_ext;
    logic [CW-1:0]        w_bnd_ext;
    logic [CW-1:0]        w_max_ext;
    logic [CW-1:0]        w_min_rm;
    logic [CW-1:0]        w_min_all;
    logic [8:0]           w_beats;
    logic [ADDR_WDTH-1:0] w_incr;
    logic [LEN_WDTH-1:0]  w_remain_sub;

    assign w_rst = !sys_rst_n || soft_rst;

    // 13 bits so that a page-aligned address yields a full 4096-byte window.
    assign w_bnd13      = 13'd4096 - {1'b0, r_addr[11:0]};
    assign w_bnd_beats  = w_bnd13 >> BSH;
    assign w_remain_ext = CW'(r_remain);
    assign w_bnd_ext    = CW'(w_bnd_beats);
    assign w_max_ext    = CW'(MAX_BURST);
    assign w_min_rm     = (w_remain_ext < w_max_ext) ? w_remain_ext : w_max_ext;
    assign w_min_all    = (w_min_rm < w_bnd_ext) ? w_min_rm : w_bnd_ext;
    assign w_beats      = 9'(w_min_all);

    assign w_incr       = ADDR_WDTH'(r_beats) << BSH;
    assign w_remain_sub = r_remain - LEN_WDTH'(r_beats);

    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_remain_nxt     = r_remain;
        w_beats_nxt      = r_beats;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_wstart_vld_nxt = r_wstart_vld;
        w_waddr_nxt      = r_waddr;
        w_wburst_len_nxt = r_wburst_len;
        w_burst_cnt_nxt  = r_burst_cnt;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (cfg_total_beats != '0) begin
                        w_addr_nxt   = cfg_base_addr & ALIGN_MASK;
                        w_remain_nxt = cfg_total_beats;
                        w_busy_nxt   = 1'b1;
                        w_state_nxt  = S_CALC;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_FIN;
                    end
                end
            end
            S_CALC: begin
                w_beats_nxt      = w_beats;
                w_waddr_nxt      = r_addr;
                w_wburst_len_nxt = 8'(w_beats - 9'd1);
                w_wstart_vld_nxt = 1'b1;
                w_state_nxt      = S_ISSUE;
            end
            S_ISSUE: begin
                if (wstart_rdy) begin
                    w_wstart_vld_nxt = 1'b0;
                    w_addr_nxt       = r_addr + w_incr;
                    w_remain_nxt     = w_remain_sub;
                    w_burst_cnt_nxt  = r_burst_cnt + 16'd1;
                    if (w_remain_sub == '0) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_FIN;
                    end else begin
                        w_state_nxt = S_CALC;
                    end
                end
            end
            S_FIN: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (w_rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_remain     <= '0;
            r_beats      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_wstart_vld <= 1'b0;
            r_waddr      <= '0;
            r_wburst_len <= '0;
            r_burst_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_remain     <= w_remain_nxt;
            r_beats      <= w_beats_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_wstart_vld <= w_wstart_vld_nxt;
            r_waddr      <= w_waddr_nxt;
            r_wburst_len <= w_wburst_len_nxt;
            r_burst_cnt  <= w_burst_cnt_nxt;
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign wstart_vld    = r_wstart_vld;
    assign waddr         = r_waddr;
    assign wburst_len    = r_wburst_len;
    assign dbg_burst_cnt = r_burst_cnt;

endmodule

// File: tb/tb_axi_wcmd_gen.sv
// Scoreboard bench for axi_wcmd_gen: stimulus queues expected (addr, len) commands, a negedge
// monitor pops and compares them on every handshake and checks command stability while stalled.
module tb_axi_wcmd_gen;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        soft_rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] cfg_base_addr = '0;
    logic [23:0] cfg_total_beats = '0;
    logic        busy;
    logic        done;
    logic        wstart_vld;
    logic        wstart_rdy = 1'b1;
    logic [31:0] waddr;
    logic [7:0]  wburst_len;
    logic [15:0] dbg_burst_cnt;

    axi_wcmd_gen #(
        .DATA_WDTH(32),
        .ADDR_WDTH(32),
        .MAX_BURST(16),
        .LEN_WDTH (24)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .soft_rst       (soft_rst),
        .start          (start),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_total_beats(cfg_total_beats),
        .busy           (busy),
        .done           (done),
        .wstart_vld     (wstart_vld),
        .wstart_rdy     (wstart_rdy),
        .waddr          (waddr),
        .wburst_len     (wburst_len),
        .dbg_burst_cnt  (dbg_burst_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          exp_cnt = 0;
    logic [39:0] exp_q[$];
    int          hs_edges[$];
    logic        prev_vld = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [7:0]  prev_len = '0;
    logic [39:0] mon_e;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (sys_rst_n && !soft_rst) begin
            if (prev_vld) begin
                check("hold_vld", 64'(wstart_vld), 64'(1));
                check("hold_addr", 64'(waddr), 64'(prev_addr));
                check("hold_len", 64'(wburst_len), 64'(prev_len));
            end
            if (wstart_vld && wstart_rdy) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_cmd: got addr 0x%0h len %0d, expected no command",
                             waddr, wburst_len);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("cmd_addr", 64'(waddr), 64'(mon_e[39:8]));
                    check("cmd_len", 64'(wburst_len), 64'(mon_e[7:0]));
                end
                hs_edges.push_back(cyc + 1);
                prev_vld = 1'b0;
            end else begin
                prev_vld = wstart_vld;
            end
            prev_addr = waddr;
            prev_len  = wburst_len;
            if (done) done_cnt++;
        end else begin
            prev_vld = 1'b0;
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push_cmd(input logic [31:0] a, input logic [7:0] l);
        exp_q.push_back({a, l});
    endtask

    task automatic do_start(input logic [31:0] base, input logic [23:0] beats, output int st_edge);
        cfg_base_addr   = base;
        cfg_total_beats = beats;
        start           = 1'b1;
        st_edge         = cyc + 1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_vld(input string nm);
        int n = 0;
        while (!wstart_vld && n < 50) begin
            step();
            n++;
        end
        check({nm, "_vld_seen"}, 64'(wstart_vld), 64'(1));
    endtask

    task automatic wait_done(input string nm, output int done_edge);
        int n = 0;
        while (!done && n < 300) begin
            step();
            n++;
        end
        check({nm, "_done_seen"}, 64'(done), 64'(1));
        done_edge = cyc;
    endtask

    // Full transfer with wstart_rdy held high; optional ignored start pulses mid-transfer.
    task automatic run_xfer(input string nm, input logic [31:0] base, input logic [23:0] beats,
                            input int ncmds, input bit pulse_mid);
        int st;
        int de;
        int d0;
        d0 = done_cnt;
        hs_edges.delete();
        do_start(base, beats, st);
        check({nm, "_busy_on"}, 64'(busy), 64'(1));
        check({nm, "_calc_novld"}, 64'(wstart_vld), 64'(0));
        if (pulse_mid) begin
            step();
            cfg_base_addr   = 32'h0000_0500;
            cfg_total_beats = 24'd7;
            start           = 1'b1;
            step();
            step();
            start = 1'b0;
            check({nm, "_busy_mid"}, 64'(busy), 64'(1));
        end
        wait_done(nm, de);
        exp_cnt += ncmds;
        check({nm, "_busy_in_fin"}, 64'(busy), 64'(1));
        check({nm, "_vld_in_fin"}, 64'(wstart_vld), 64'(0));
        check({nm, "_q_empty"}, 64'(exp_q.size()), 64'(0));
        check({nm, "_hs_count"}, 64'(hs_edges.size()), 64'(ncmds));
        if (hs_edges.size() == ncmds && ncmds > 0) begin
            check({nm, "_first_hs"}, 64'(hs_edges[0]), 64'(st + 2));
            for (int i = 1; i < ncmds; i++)
                check({nm, "_cadence"}, 64'(hs_edges[i] - hs_edges[i-1]), 64'(2));
            check({nm, "_done_edge"}, 64'(de), 64'(hs_edges[ncmds-1]));
        end
        step();
        check({nm, "_busy_off"}, 64'(busy), 64'(0));
        check({nm, "_done_off"}, 64'(done), 64'(0));
        check({nm, "_burst_cnt"}, 64'(dbg_burst_cnt), 64'(exp_cnt));
        check({nm, "_done_once"}, 64'(done_cnt - d0), 64'(1));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int de;
        int d0;

        repeat (3) step();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_vld", 64'(wstart_vld), 64'(0));
        check("rst_waddr", 64'(waddr), 64'(0));
        check("rst_len", 64'(wburst_len), 64'(0));
        check("rst_cnt", 64'(dbg_burst_cnt), 64'(0));
        sys_rst_n = 1'b1;
        step();

        // 4 KB split, then max-burst split back-to-back
        push_cmd(32'h0000_0FF0, 8'd3);
        push_cmd(32'h0000_1000, 8'd15);
        run_xfer("split4k", 32'h0000_0FF0, 24'd20, 2, 1'b0);
        push_cmd(32'h0000_0100, 8'd15);
        push_cmd(32'h0000_0140, 8'd15);
        push_cmd(32'h0000_0180, 8'd7);
        run_xfer("maxburst", 32'h0000_0100, 24'd40, 3, 1'b0);

        // back-pressure on the first burst
        wstart_rdy = 1'b0;
        push_cmd(32'h0000_0FF0, 8'd3);
        push_cmd(32'h0000_1000, 8'd15);
        d0 = done_cnt;
        do_start(32'h0000_0FF0, 24'd20, st);
        wait_vld("bp");
        for (int i = 0; i < 5; i++) begin
            check("bp_stall_vld", 64'(wstart_vld), 64'(1));
            check("bp_stall_addr", 64'(waddr), 64'h0FF0);
            check("bp_stall_len", 64'(wburst_len), 64'(3));
            step();
        end
        wstart_rdy = 1'b1;
        wait_done("bp", de);
        exp_cnt += 2;
        check("bp_q_empty", 64'(exp_q.size()), 64'(0));
        step();
        check("bp_burst_cnt", 64'(dbg_burst_cnt), 64'(exp_cnt));
        check("bp_done_once", 64'(done_cnt - d0), 64'(1));
        check("bp_busy_off", 64'(busy), 64'(0));

        // zero-length start
        d0 = done_cnt;
        do_start(32'h0000_0200, 24'd0, st);
        check("zero_done", 64'(done), 64'(1));
        check("zero_busy", 64'(busy), 64'(0));
        check("zero_vld", 64'(wstart_vld), 64'(0));
        step();
        check("zero_done_off", 64'(done), 64'(0));
        repeat (3) begin
            check("zero_no_vld", 64'(wstart_vld), 64'(0));
            step();
        end
        check("zero_done_once", 64'(done_cnt - d0), 64'(1));
        check("zero_burst_cnt", 64'(dbg_burst_cnt), 64'(exp_cnt));

        // misaligned base
        push_cmd(32'h0000_0100, 8'd0);
        run_xfer("misalign", 32'h0000_0103, 24'd1, 1, 1'b0);

        // abort during second of three bursts
        wstart_rdy = 1'b0;
        push_cmd(32'h0000_0100, 8'd15);
        do_start(32'h0000_0100, 24'd40, st);
        wait_vld("abort1");
        wstart_rdy = 1'b1;
        step();
        wstart_rdy = 1'b0;
        wait_vld("abort2");
        check("abort_2nd_addr", 64'(waddr), 64'h0140);
        check("abort_q_empty", 64'(exp_q.size()), 64'(0));
        soft_rst = 1'b1;
        step();
        soft_rst = 1'b0;
        exp_cnt  = 0;
        d0       = done_cnt;
        check("abort_vld", 64'(wstart_vld), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_cnt", 64'(dbg_burst_cnt), 64'(0));
        check("abort_waddr", 64'(waddr), 64'(0));
        repeat (5) step();
        check("abort_no_done", 64'(done_cnt - d0), 64'(0));
        check("abort_idle_vld", 64'(wstart_vld), 64'(0));
        wstart_rdy = 1'b1;
        push_cmd(32'h0000_0100, 8'd0);
        run_xfer("post_abort", 32'h0000_0103, 24'd1, 1, 1'b0);

        // address wrap with ignored start pulses mid-transfer
        push_cmd(32'hFFFF_FFF8, 8'd1);
        push_cmd(32'h0000_0000, 8'd1);
        run_xfer("wrap", 32'hFFFF_FFF8, 24'd4, 2, 1'b1);
        repeat (4) begin
            check("wrap_idle_busy", 64'(busy), 64'(0));
            check("wrap_idle_vld", 64'(wstart_vld), 64'(0));
            step();
        end
        check("wrap_q_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_wcmd_gen.md
# axi_wcmd_gen

Write-command generator that sits directly upstream of the FIFO-to-AXI write bridge and drives its `wstart_vld` / `wstart_rdy` / `waddr` / `wburst_len` command port. Software or a control FSM gives it a base address and a total transfer length in data beats. It splits the transfer into AXI INCR bursts, none longer than `MAX_BURST` beats and none crossing a 4 KB boundary, and issues them one at a time through a valid/ready handshake. It runs on the bridge's `sys_clk` domain.

## Interface
Parameters:
- `DATA_WDTH`, 32: AXI data width in bits. Bytes per beat is BPB = DATA_WDTH/8, a power of two.
- `ADDR_WDTH`, 32: byte address width.
- `MAX_BURST`, 16: maximum beats per burst, 1..256.
- `LEN_WDTH`, 24: width of the total-beat counter.

Ports:
- `sys_clk`  in  1  block clock.
- `sys_rst_n`  in  1  reset, synchronous, active-low.
- `soft_rst`  in  1  synchronous abort, active-high, same effect as reset.
- `start`  in  1  one-cycle request to start a transfer.
- `cfg_base_addr`  in  ADDR_WDTH  byte start address, sampled on an accepted `start`.
- `cfg_total_beats`  in  LEN_WDTH  total beats to write, sampled on an accepted `start`.
- `busy`  out  1  high from the accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the last burst has been handed off.
- `wstart_vld`  out  1  command valid.
- `wstart_rdy`  in  1  command accepted by the bridge.
- `waddr`  out  ADDR_WDTH  burst start byte address.
- `wburst_len`  out  8  AXI length encoding, beats-1.
- `dbg_burst_cnt`  out  16  count of bursts issued since the last reset/soft_rst; wraps at 2^16.

## Operation
- State machine states: IDLE, CALC, ISSUE, FIN.
- **IDLE**
  - `start`=1 with `cfg_total_beats`≠0: latch `addr` = `cfg_base_addr` with the low log2(BPB) bits forced to 0, latch `remain` = `cfg_total_beats`, set `busy`=1, go to CALC.
  - `start`=1 with `cfg_total_beats`=0: go to FIN with no command issued.
- **CALC** (1 cycle)
  - `bnd` = (4096 − addr[11:0]) / BPB. Use a 13-bit intermediate so that addr[11:0]=0 gives 4096/BPB.
  - `beats` = min(`remain`, `MAX_BURST`, `bnd`). `beats` is always ≥1.
  - Register `waddr`=`addr` and `wburst_len`=`beats`−1, then go to ISSUE.
- **ISSUE**
  - Hold `wstart_vld`=1 with `waddr`/`wburst_len` stable until `wstart_rdy`=1.
  - On the handshake: `addr` += `beats`×BPB (modulo 2^ADDR_WDTH), `remain` −= `beats`, `dbg_burst_cnt`++.
  - If the new `remain`=0, go to FIN; otherwise go to CALC.
- **FIN** (1 cycle)
  - `done`=1 and `busy`=0 on the next cycle, then go to IDLE.
- `start` outside IDLE is ignored. It is neither queued nor does it affect `busy`.
- `sys_rst_n`=0 or `soft_rst`=1 (sampled at the clock edge):
  - state→IDLE; all outputs take their reset values; `remain`/`addr` are cleared.
  - An in-flight `wstart_vld` drops on the next cycle without a handshake. The bridge receives its own soft reset in parallel.
  - `soft_rst` has priority over `start` in the same cycle.

## Timing
- Reset values: `busy`=0, `done`=0, `wstart_vld`=0, `waddr`=0, `wburst_len`=0, `dbg_burst_cnt`=0.
- All outputs are registered.
- `start` at edge N: `busy`=1 from N+1, CALC in N+1, `wstart_vld`=1 from N+2.
- Handshake at edge M (vld & rdy):
  - More bursts remain: `wstart_vld`=0 for exactly one cycle (CALC), new command valid from M+2.
  - Last burst: `wstart_vld`=0 from M+1, FIN in M+1 with `done`=1, `busy`=0 from M+2.
- Zero-length start at edge N: `done`=1 in cycle N+1, no `wstart_vld`.
- Back-to-back: `start` in the cycle after `done` is accepted (IDLE).
- Throughput: one command per 2 cycles at most.

## Test plan
- **4 KB split.** Parameters: DATA_WDTH=32, MAX_BURST=16. Stimulus: base 0x0000_0FF0, 20 beats. Required: two commands, (0x0FF0, len 3) then (0x1000, len 15); `done` once; `dbg_burst_cnt`=2.
- **Max-burst split.** Stimulus: base 0x100, 40 beats. Required: (0x100, 15), (0x140, 15), (0x180, 7); `done` 1 cycle after the third handshake.
- **Back-pressure.** Hold `wstart_rdy`=0 for 5 cycles on the first burst. Required: `wstart_vld` stays 1 and `waddr`/`wburst_len` are unchanged through the stall; the sequence completes identically once `wstart_rdy` is released.
- **Zero length and misalignment.**
  - Stimulus: 0 beats. Required: `done` at N+1, no command.
  - Stimulus: base 0x103, 1 beat. Required: (0x100, len 0).
- **Abort.** Assert `soft_rst` while `wstart_vld`=1 on the second of three bursts. Required: `wstart_vld`, `busy` and `dbg_burst_cnt` are 0 next cycle; no `done`; a new `start` then runs normally.
- **Address wrap and ignored start.** Stimulus: base 0xFFFF_FFF8, 4 beats. Required: (0xFFFF_FFF8, len 1) then (0x0000_0000, len 1). Pulse `start` again mid-transfer; it must have no effect.
